i_buf_ds_rx_monitor: RTL

Receive-side companion to the differential tri-state output buffer test block. It takes a raw differential pad pair (I_P/I_N) and synchronizes both legs into the clk domain. It resolves the pair into a single-ended bit, filters glitches, and counts edges. It also flags invalid (P==N) conditions, so a transmitter under test can be checked in loopback with a bounded, deterministic verdict.

---
 rtl/i_buf_ds_rx_monitor_pkg.sv | 23 ++
 rtl/i_buf_ds_rx_monitor_ds_pair_sync.sv | 43 ++++
 rtl/i_buf_ds_rx_monitor.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/i_buf_ds_rx_monitor_pkg.sv
// -----------------------------------------------------------------------------
// i_buf_ds_rx_monitor_pkg
// Shared definitions for the differential receive monitor: FSM state encoding
// and the decode of the raw {P,N} pad pair into a single-ended bit.
// -----------------------------------------------------------------------------
package i_buf_ds_rx_monitor_pkg;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2,
    ST_FAULT    = 2'd3
  } rx_state_e;

  // Pair encodings, packed as {P, N}. Anything else (P==N) is invalid.
  localparam logic [1:0] PAIR_ONE  = 2'b10;
  localparam logic [1:0] PAIR_ZERO = 2'b01;

  function automatic logic pair_is_valid(input logic [1:0] pn);
    return (pn == PAIR_ONE) || (pn == PAIR_ZERO);
  endfunction

endpackage

// File: rtl/i_buf_ds_rx_monitor_ds_pair_sync.sv
// -----------------------------------------------------------------------------
// ds_pair_sync
// Two-flop synchronizer on each leg of an asynchronous differential pair,
// followed by the pair decode.
//   clk, rst_n  : sampling clock, async active-low reset
//   p_i, n_i    : raw pad legs (asynchronous to clk)
//   s_o         : resolved single-ended bit (meaningful only when s_valid_o)
//   s_valid_o   : high when the synchronized legs differ
// -----------------------------------------------------------------------------
module ds_pair_sync
  import i_buf_ds_rx_monitor_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic p_i,
  input  logic n_i,
  output logic s_o,
  output logic s_valid_o
);

  logic [1:0] p_q;
  logic [1:0] n_q;
  logic [1:0] pair;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the
  // two synchronizer stages into one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= '0;
      n_q <= '0;
    end else begin
      p_q <= {p_q[0], p_i};
      n_q <= {n_q[0], n_i};
    end
  end

  // Decode only from the second stage; the first may be metastable.
  assign pair      = {p_q[1], n_q[1]};
  assign s_valid_o = pair_is_valid(pair);
  assign s_o       = (pair == PAIR_ONE);

endmodule

// File: rtl/i_buf_ds_rx_monitor.sv
// -----------------------------------------------------------------------------
// i_buf_ds_rx_monitor
// Receive-side loopback monitor for a differential tri-state output buffer.
// Synchronizes and decodes the pad pair, glitch-filters it into O, counts
// filtered edges while locked and flags persistent invalid (P==N) pairs.
//   clk, rst_n        : sampling clock, async active-low reset
//   I_P, I_N          : differential pad legs (asynchronous)
//   EN                : receiver enable; low holds O/counters, drops to DISABLED
//   clr               : synchronous clear of counters and sticky fault
//   O                 : filtered data
//   valid             : high while LOCKED
//   fault             : sticky invalid-pair fault
//   rise_cnt/fall_cnt : saturating counts of filtered O edges while LOCKED
// -----------------------------------------------------------------------------
module i_buf_ds_rx_monitor
  import i_buf_ds_rx_monitor_pkg::*;
#(
  parameter int unsigned FILTER_LEN    = 3,
  parameter int unsigned INVALID_LIMIT = 8,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             I_P,
  input  logic             I_N,
  input  logic             EN,
  input  logic             clr,
  output logic             O,
  output logic             valid,
  output logic             fault,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] fall_cnt
);

  localparam int unsigned MCNT_W = $clog2(FILTER_LEN + 1);
  localparam int unsigned INV_W  = $clog2(INVALID_LIMIT + 1);
  localparam logic [MCNT_W-1:0] MCNT_FULL = MCNT_W'(FILTER_LEN);
  localparam logic [INV_W-1:0]  INV_FULL  = INV_W'(INVALID_LIMIT);

  // Reset asserts asynchronously but releases on a clock edge, so no flop
  // leaves reset on a partial cycle.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  logic s;
  logic s_valid;

  ds_pair_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_int_n),
    .p_i       (I_P),
    .n_i       (I_N),
    .s_o       (s),
    .s_valid_o (s_valid)
  );

  rx_state_e         state_q, state_d;
  logic              cand_q, cand_d;
  logic [MCNT_W-1:0] mcnt_q, mcnt_d;
  logic [INV_W-1:0]  inv_q, inv_d;
  logic              o_q, o_d;
  logic              fault_q, fault_d;
  logic [CNT_W-1:0]  rise_q, rise_d;
  logic [CNT_W-1:0]  fall_q, fall_d;
  logic              filt_full, inv_full, enter_fault, active;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign active = EN && (state_q != ST_DISABLED);

  // Glitch filter: run length of identical valid samples, cleared whenever
  // the receiver is (or is becoming) disabled so partial matches are lost.
  // NOTE: every variable driven in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cand_d = cand_q;
    mcnt_d = mcnt_q;
    if (!active) begin
      cand_d = 1'b0;
      mcnt_d = '0;
    end else if (!s_valid) begin
      mcnt_d = '0;
    end else if (s != cand_q) begin
      cand_d = s;
      mcnt_d = MCNT_W'(1);
    end else if (mcnt_q != MCNT_FULL) begin
      mcnt_d = mcnt_q + 1'b1;
    end
  end

  // Invalid run length; only meaningful while hunting for or holding lock.
  always_comb begin
    inv_d = '0;
    if (active && !s_valid && (state_q == ST_ACQUIRE || state_q == ST_LOCKED))
      inv_d = (inv_q == INV_FULL) ? inv_q : inv_q + 1'b1;
  end

  // Decisions use the next-state run lengths so O follows a stable pad
  // after exactly 2 sync + FILTER_LEN cycles.
  assign filt_full = (mcnt_d == MCNT_FULL);
  assign inv_full  = (inv_d == INV_FULL);

  always_comb begin
    state_d     = state_q;
    o_d         = o_q;
    fault_d     = fault_q;
    rise_d      = rise_q;
    fall_d      = fall_q;
    enter_fault = 1'b0;
    if (!EN) begin
      state_d = ST_DISABLED;
    end else begin
      case (state_q)
        ST_DISABLED: state_d = ST_ACQUIRE;
        ST_ACQUIRE: begin
          if (filt_full) begin
            // Initial lock: adopt the filtered value without counting an edge.
            state_d = ST_LOCKED;
            o_d     = cand_d;
          end else if (inv_full) begin
            state_d     = ST_FAULT;
            enter_fault = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (inv_full) begin
            state_d     = ST_FAULT;
            enter_fault = 1'b1;
          end else if (filt_full && (cand_d != o_q)) begin
            o_d = cand_d;
            if (cand_d) rise_d = sat_inc(rise_q);
            else        fall_d = sat_inc(fall_q);
          end
        end
        ST_FAULT: if (s_valid) state_d = ST_ACQUIRE;
      endcase
    end
    // clr beats a coincident edge count; fault entry beats clr.
    if (clr) begin
      rise_d  = '0;
      fall_d  = '0;
      fault_d = 1'b0;
    end
    if (enter_fault) fault_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= ST_DISABLED;
      cand_q  <= 1'b0;
      mcnt_q  <= '0;
      inv_q   <= '0;
      o_q     <= 1'b0;
      fault_q <= 1'b0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      mcnt_q  <= mcnt_d;
      inv_q   <= inv_d;
      o_q     <= o_d;
      fault_q <= fault_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign O        = o_q;
  assign valid    = (state_q == ST_LOCKED);
  assign fault    = fault_q;
  assign rise_cnt = rise_q;
  assign fall_cnt = fall_q;

endmodule
